// File: rtl/fetch_ctrl_if.sv
// Purpose: bus bundle between the fetch sequencer, the instruction memory
//          and the decoder.
// Signals:
//   read_address   - fetch address to instruction memory (driven by master)
//   instruction_in - memory read data, combinational from read_address
//   instr_out      - registered instruction toward the decoder (master)
//   instr_valid    - instr_out holds an unconsumed instruction (master)
//   instr_ready    - decoder accepts instr_out on valid && ready
// Modports: master = fetch sequencer, slave = memory/decoder side.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 8
);
  logic [ADDR_W-1:0]  read_address;
  logic [INSTR_W-1:0] instruction_in;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output read_address, instr_out, instr_valid,
    input  instruction_in, instr_ready
  );

  modport slave (
    input  read_address, instr_out, instr_valid,
    output instruction_in, instr_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Purpose: instruction-fetch sequencer. Owns the PC, drives the memory
//          address and registers each fetched word into a one-entry
//          valid/ready output stage toward the decoder. Handles start,
//          branch redirect, halt opcode and external stop.
// Ports:
//   clk           - rising-edge clock
//   reset         - synchronous active-low reset
//   start         - pulse, begins fetching at RESET_PC from IDLE or DONE
//   stop          - level, halts further fetches
//   branch_valid  - one-cycle redirect request (FETCH only)
//   branch_target - redirect address
//   busy          - state is FETCH or DRAIN
//   done          - state is DONE
//   bus           - memory address/data and decoder handshake (master)
// Build option: define FETCH_WRAP_EN to let the PC wrap from the last
//   address to 0 and keep fetching; otherwise fetching ends there.
module fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 4,
  parameter int unsigned        INSTR_W  = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INSTR_W-1:0] HALT_OP  = INSTR_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              busy,
  output logic              done,
  fetch_ctrl_if.master      bus
);

`ifdef FETCH_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_out_q;
  logic               instr_valid_q;
  logic               busy_q;
  logic               done_q;

  logic accept_c;
  logic slot_free_c;
  logic is_halt_c;
  logic stop_at_end_c;

  // Handshake status of the output stage and capture qualifiers.
  assign accept_c      = instr_valid_q && bus.instr_ready;
  assign slot_free_c   = !instr_valid_q || bus.instr_ready;
  assign is_halt_c     = (bus.instruction_in == HALT_OP);
  assign stop_at_end_c = (pc_q == PC_LAST) && !WRAP_EN;

  assign bus.read_address = pc_q;
  assign bus.instr_out    = instr_out_q;
  assign bus.instr_valid  = instr_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

  // Sequencer: state, PC, output stage and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_out_q   <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_valid_q <= 1'b0;
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          if (branch_valid) begin
            // Pending word is dropped (or already taken this cycle).
            pc_q          <= branch_target;
            instr_valid_q <= 1'b0;
            if (stop) state_q <= S_DRAIN;
          end else if (stop) begin
            if (accept_c) instr_valid_q <= 1'b0;
            state_q <= S_DRAIN;
          end else if (slot_free_c) begin
            instr_out_q   <= bus.instruction_in;
            instr_valid_q <= 1'b1;
            if (is_halt_c || stop_at_end_c) begin
              // Halt word / last address: present it, keep PC, wind down.
              state_q <= S_DRAIN;
            end else begin
              pc_q <= pc_q + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (slot_free_c) begin
            state_q       <= S_DONE;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end
        end
        S_DONE: begin
          instr_valid_q <= 1'b0;
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          instr_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: self-checking bench for fetch_ctrl. A cycle table covers reset,
// straight-line fetch, back-pressure, IDLE input masking, mid-fetch reset
// and stop; hand sequences cover branch redirect and end-of-memory; random
// programs with random back-pressure are checked against a list of the
// words the program should deliver.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       bv;
  logic [3:0] bt;
  logic       rdy;
  logic       busy;
  logic       done;
  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(4), .INSTR_W(8)) bus ();

  assign bus.instruction_in = mem[bus.read_address];
  assign bus.instr_ready    = rdy;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start),
    .stop          (stop),
    .branch_valid  (bv),
    .branch_target (bt),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

`ifdef FETCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic       rst_n, start, stop, bv;
    logic [3:0] bt;
    logic       rdy;
    logic [3:0] e_ra;
    logic [7:0] e_out;
    logic       e_v, e_busy, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic sp, logic b, logic [3:0] t,
                              logic y, logic [3:0] ra, logic [7:0] o,
                              logic v, logic bz, logic dn);
    vec_t x;
    x.rst_n = r; x.start = s; x.stop = sp; x.bv = b; x.bt = t; x.rdy = y;
    x.e_ra = ra; x.e_out = o; x.e_v = v; x.e_busy = bz; x.e_done = dn;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic sp, input logic b,
                      input logic [3:0] t, input logic y);
    rst_n = r; start = s; stop = sp; bv = b; bt = t; rdy = y;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ra, input logic [7:0] o,
                         input logic v, input logic bz, input logic dn);
    chk({tag, ".ra"},    32'(bus.read_address), 32'(ra));
    chk({tag, ".out"},   32'(bus.instr_out),    32'(o));
    chk({tag, ".valid"}, 32'(bus.instr_valid),  32'(v));
    chk({tag, ".busy"},  32'(busy),             32'(bz));
    chk({tag, ".done"},  32'(done),             32'(dn));
  endtask

  // Words a program should hand to the decoder, in order, and the final PC.
  task automatic model(output logic [7:0] exp_q[$], output logic [3:0] end_pc);
    int a = 0;
    exp_q = {};
    for (int n = 0; n < 64; n++) begin
      exp_q.push_back(mem[a]);
      if (mem[a] == 8'hFF) break;
      if (a == 15 && !WRAP) break;
      a = (a + 1) % 16;
    end
    end_pc = 4'(a);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [3:0] end_pc;
    logic       pv;
    logic [7:0] pout;
    logic       y;
    int         cyc;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; bv = 1'b0; bt = '0; rdy = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFF;

    //            rst st sp bv bt  rdy  ra  out   v bz dn
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 0)); // idle
    tbl.push_back(mk(1, 1, 0, 0, 0, 1,  0, 8'h00, 0, 1, 0)); // start
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  2, 8'h02, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  3, 8'h03, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  3, 8'hFF, 1, 1, 0)); // halt word
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  3, 8'hFF, 0, 0, 1)); // done
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  3, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 8'hFF, 0, 1, 0)); // restart, stalled
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  2, 8'h02, 1, 1, 0)); // resume
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  3, 8'h03, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  3, 8'hFF, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  3, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1,  0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0)); // reset mid-fetch
    tbl.push_back(mk(1, 0, 1, 1, 9, 0,  0, 8'h00, 0, 0, 0)); // idle ignores bv/stop
    tbl.push_back(mk(1, 1, 0, 0, 0, 1,  0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0,  1, 8'h01, 1, 1, 0)); // stop while stalled
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 8'h01, 0, 0, 1)); // accepted -> done

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].start, tbl[i].stop, tbl[i].bv, tbl[i].bt, tbl[i].rdy);
      chk_all($sformatf("vec%0d", i), tbl[i].e_ra, tbl[i].e_out,
              tbl[i].e_v, tbl[i].e_busy, tbl[i].e_done);
    end

    // Branch redirect while a word is stalled.
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[9] = 8'hFF;
    step(1, 1, 0, 0, 0, 1); chk_all("br.start", 0, 8'h01, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0); chk_all("br.w0",    1, 8'h10, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1); chk_all("br.w1",    2, 8'h11, 1, 1, 0);
    step(1, 0, 0, 1, 9, 0); chk_all("br.flush", 9, 8'h11, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0); chk_all("br.tgt",   9, 8'hFF, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1); chk_all("br.done",  9, 8'hFF, 0, 0, 1);

    // Branch together with stop, pending word accepted the same cycle.
    step(1, 1, 0, 0, 0, 1); chk_all("bs.start", 0, 8'hFF, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1); chk_all("bs.w0",    1, 8'h10, 1, 1, 0);
    step(1, 0, 1, 1, 5, 1); chk_all("bs.br",    5, 8'h10, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1); chk_all("bs.done",  5, 8'h10, 0, 0, 1);

    // End of memory with no halt opcode.
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h20 + i);
    step(1, 1, 0, 0, 0, 1); chk_all("end.start", 0, 8'h10, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0, 0, 0, 1);
      chk($sformatf("end.out%0d", k), 32'(bus.instr_out), 32'(8'h20 + k - 1));
    end
    if (WRAP) begin
      chk_all("wrap.pc0", 0, 8'h2F, 1, 1, 0);
      step(1, 0, 0, 0, 0, 1); chk_all("wrap.again", 1, 8'h20, 1, 1, 0);
      step(1, 0, 1, 0, 0, 1); chk_all("wrap.stop",  1, 8'h20, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1); chk_all("wrap.done",  1, 8'h20, 0, 0, 1);
    end else begin
      chk_all("nowrap.last", 15, 8'h2F, 1, 1, 0);
      step(1, 0, 0, 0, 0, 1); chk_all("nowrap.done", 15, 8'h2F, 0, 0, 1);
    end

    // Random programs under random back-pressure.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 254));
      if (WRAP || ($urandom_range(0, 1) == 1)) mem[$urandom_range(0, 15)] = 8'hFF;
      model(exp_q, end_pc);
      got = {};
      step(1, 1, 0, 0, 0, 1'($urandom_range(0, 1)));
      cyc = 0;
      while (!done && cyc < 300) begin
        y = ($urandom_range(0, 3) != 0);
        pv = bus.instr_valid;
        pout = bus.instr_out;
        if (pv && y) got.push_back(pout);
        step(1, 0, 0, 0, 0, y);
        cyc++;
        if (pv && !y) begin
          chk($sformatf("rnd%0d.hold_v", t),   32'(bus.instr_valid), 32'(1));
          chk($sformatf("rnd%0d.hold_out", t), 32'(bus.instr_out),   32'(pout));
        end
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL rnd%0d.timeout actual=busy required=done", t);
      end
      chk($sformatf("rnd%0d.count", t), 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        chk($sformatf("rnd%0d.word%0d", t, i), 32'(got[i]), 32'(exp_q[i]));
      chk($sformatf("rnd%0d.end_pc", t), 32'(bus.read_address), 32'(end_pc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
